// File: rtl/morse_symbol_sequencer_if.sv
// Character record stream from the Morse symbol sequencer to the
// character decoder / UART stage.
//   master : drives out_pattern, out_len, out_word_end, out_err, out_valid;
//            samples out_ready.
//   slave  : the consumer side of the same handshake.
// A record transfers on any clock edge where out_valid && out_ready.
interface morse_symbol_sequencer_if #(
  parameter int MAXLEN = 6,
  parameter int LENW   = $clog2(MAXLEN + 1)
) ();
  logic [MAXLEN-1:0] out_pattern;
  logic [LENW-1:0]   out_len;
  logic              out_word_end;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_pattern, out_len, out_word_end, out_err, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_pattern, out_len, out_word_end, out_err, out_valid,
    output out_ready
  );
endinterface

// File: rtl/morse_symbol_sequencer.sv
// Morse symbol sequencer.
// Collects DIT/DAH elements from the dit/dah classifier into a pattern and
// closes a character on GAP (end of character) or SPACE (end of word). Each
// finished character becomes a record in a small FIFO that is drained over
// a valid/ready handshake.
//
// Ports:
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   sym        : 0 WAIT, 1 DIT, 2 DAH, 3 GAP, 4 SPACE, 5..7 illegal
//   sym_valid  : single-cycle strobe qualifying sym
//   rec        : record stream (pattern, len, word_end, err, valid / ready)
//   drop       : one-cycle pulse when a record is lost to a full FIFO
//   busy       : high while a character is being collected
//
// Optional build macro: MORSE_TIMEOUT_EN flushes a partial character as a
// word-ending record after TIMEOUT idle cycles.
module morse_symbol_sequencer #(
  parameter int MAXLEN  = 6,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2**24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               sym,
  input  logic                     sym_valid,
  morse_symbol_sequencer_if.master rec,
  output logic                     drop,
  output logic                     busy
);
  localparam int LENW = $clog2(MAXLEN + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_param
    $error("morse_symbol_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
  end

  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  typedef enum logic {IDLE, COLLECT} state_t;

  typedef struct packed {
    logic [MAXLEN-1:0] pattern;
    logic [LENW-1:0]   len;
    logic              word_end;
    logic              err;
  } rec_t;

  state_t            state, state_n;
  logic [MAXLEN-1:0] pattern, pattern_n;
  logic [LENW-1:0]   len, len_n;
  logic              err, err_n;
  logic              prev_space, prev_space_n;
  logic              push;
  rec_t              push_rec;

  // WAIT and illegal codes are filtered here so they touch no state at all.
  logic is_elem, is_dah, is_gap, is_space, accepted;
  assign is_dah   = sym_valid && (sym == SYM_DAH);
  assign is_elem  = sym_valid && ((sym == SYM_DIT) || (sym == SYM_DAH));
  assign is_gap   = sym_valid && (sym == SYM_GAP);
  assign is_space = sym_valid && (sym == SYM_SPACE);
  assign accepted = is_elem || is_gap || is_space;

`ifdef MORSE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;
  logic          timeout_hit;
  // An accepted symbol on the expiry cycle wins; the timeout is cancelled.
  assign timeout_hit = (state == COLLECT) && !accepted && (tcnt == TW'(TIMEOUT - 1));
`endif

  // ---------------------------------------------------------------------
  // Next-state / accumulator logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_n      = state;
    pattern_n    = pattern;
    len_n        = len;
    err_n        = err;
    prev_space_n = prev_space;
    push         = 1'b0;
    push_rec     = '0;

    if (accepted) prev_space_n = is_space;

    unique case (state)
      IDLE: begin
        if (is_elem) begin
          pattern_n = MAXLEN'(is_dah);
          len_n     = LENW'(1);
          err_n     = 1'b0;
          state_n   = COLLECT;
        end else if (is_space && !prev_space) begin
          // Bare word break; repeated spaces collapse into one record.
          push              = 1'b1;
          push_rec.word_end = 1'b1;
        end
      end
      COLLECT: begin
        if (is_elem) begin
          if (len < LENW'(MAXLEN)) begin
            for (int i = 0; i < MAXLEN; i++) begin
              if (LENW'(i) == len) pattern_n[i] = is_dah;
            end
            len_n = len + LENW'(1);
          end else begin
            // Overlong character: keep the first MAXLEN elements, flag it.
            err_n = 1'b1;
          end
        end else if (is_gap || is_space) begin
          push      = 1'b1;
          push_rec  = '{pattern: pattern, len: len, word_end: is_space, err: err};
          pattern_n = '0;
          len_n     = '0;
          err_n     = 1'b0;
          state_n   = IDLE;
        end
`ifdef MORSE_TIMEOUT_EN
        else if (timeout_hit) begin
          push         = 1'b1;
          push_rec     = '{pattern: pattern, len: len, word_end: 1'b1, err: err};
          pattern_n    = '0;
          len_n        = '0;
          err_n        = 1'b0;
          prev_space_n = 1'b1;
          state_n      = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pattern    <= '0;
      len        <= '0;
      err        <= 1'b0;
      prev_space <= 1'b0;
    end else begin
      state      <= state_n;
      pattern    <= pattern_n;
      len        <= len_n;
      err        <= err_n;
      prev_space <= prev_space_n;
    end
  end

`ifdef MORSE_TIMEOUT_EN
  // Idle counter: runs only while collecting, restarts on any accepted symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          tcnt <= '0;
    else if (state_n != COLLECT || accepted) tcnt <= '0;
    else                                 tcnt <= tcnt + TW'(1);
  end
`endif

  assign busy = (state == COLLECT);

  // ---------------------------------------------------------------------
  // Record FIFO
  // ---------------------------------------------------------------------
  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_pop, do_push;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rec.out_valid && rec.out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; validity lives in count and the
  // outputs are masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  rec_t head;
  assign head             = mem[rd_ptr];
  assign rec.out_valid    = (count != '0);
  assign rec.out_pattern  = rec.out_valid ? head.pattern  : '0;
  assign rec.out_len      = rec.out_valid ? head.len      : '0;
  assign rec.out_word_end = rec.out_valid && head.word_end;
  assign rec.out_err      = rec.out_valid && head.err;
endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Self-checking bench for morse_symbol_sequencer (default build, MAXLEN = 6,
// DEPTH = 4). Directed symbol sequences push hand-computed records into a
// scoreboard queue; a monitor pops and compares on every accepted transfer.
module tb_morse_symbol_sequencer;
  localparam logic [2:0] WAIT = 3'd0, DIT = 3'd1, DAH = 3'd2, GAP = 3'd3, SPACE = 3'd4;

  typedef struct packed {
    logic [5:0] pat;
    logic [2:0] len;
    logic       we;
    logic       err;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] sym = '0;
  logic       sym_valid = 1'b0;
  logic       drop, busy;

  morse_symbol_sequencer_if #(.MAXLEN(6)) dif ();

  morse_symbol_sequencer #(.MAXLEN(6), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym       (sym),
    .sym_valid (sym_valid),
    .rec       (dif),
    .drop      (drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   drop_cnt = 0;
  rec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [5:0] p, input int l, input logic w, input logic e);
    mk = '{pat: p, len: 3'(l), we: w, err: e};
  endfunction

  function automatic rec_t head();
    head = '{pat: dif.out_pattern, len: dif.out_len, we: dif.out_word_end, err: dif.out_err};
  endfunction

  // Monitor: compare every transferred record against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && dif.out_valid && dif.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record actual=%0h expected=none", head());
      end else begin
        check("record", 32'(head()), 32'(sb.pop_front()));
      end
    end
    if (drop) drop_cnt++;
  end

  // Called at posedge+1; the symbol is sampled on the next rising edge.
  task automatic send(input logic [2:0] s);
    sym       = s;
    sym_valid = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    sym       = WAIT;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!dif.out_valid && sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({name, "_valid_low"}, 32'(dif.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    dif.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid", 32'(dif.out_valid), 0);
    check("rst_pattern", 32'(dif.out_pattern), 0);
    check("rst_len", 32'(dif.out_len), 0);
    check("rst_flags", {30'd0, dif.out_word_end, dif.out_err}, 0);
    check("rst_drop_busy", {30'd0, drop, busy}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: DIT DAH GAP with illegal/WAIT codes interleaved; one-cycle latency.
    dif.out_ready = 1'b1;
    send(DIT);
    check("t1_busy", 32'(busy), 1);
    send(3'd7);
    send(DAH);
    send(WAIT);
    check("t1_pre_gap_valid", 32'(dif.out_valid), 0);
    sb.push_back(mk(6'b000010, 2, 0, 0));
    send(GAP);
    check("t1_latency_valid", 32'(dif.out_valid), 1);
    check("t1_idle", 32'(busy), 0);
    wait_drain("t1");

    // 2: repeated spaces collapse; an illegal code leaves prev_space alone.
    sb.push_back(mk(6'b000001, 3, 1, 0));
    send(DAH); send(DIT); send(DIT); send(SPACE); send(SPACE); send(3'd6); send(SPACE);
    sb.push_back(mk(6'b000000, 1, 0, 0));
    send(DIT); send(3'd5); send(GAP);
    sb.push_back(mk(6'b000000, 0, 1, 0));
    send(SPACE);
    wait_drain("t2");

    // 3: overlong characters truncate and flag err; the next one is clean.
    sb.push_back(mk(6'b000000, 6, 0, 1));
    repeat (7) send(DIT);
    send(GAP);
    sb.push_back(mk(6'b111111, 6, 0, 1));
    repeat (8) send(DAH);
    send(GAP);
    sb.push_back(mk(6'b000001, 1, 0, 0));
    send(DAH); send(GAP);
    wait_drain("t3");

    // 4: stalled consumer, five characters into a 4-deep FIFO.
    dif.out_ready = 1'b0;
    d0 = drop_cnt;
    repeat (4) sb.push_back(mk(6'b000000, 1, 0, 0));
    repeat (5) begin send(DIT); send(GAP); end
    repeat (2) @(posedge clk);
    #1;
    check("t4_drop_once", 32'(drop_cnt - d0), 1);
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_valid", 32'(dif.out_valid), 1);
      check("t4_stall_head", 32'(head()), 32'(mk(6'b000000, 1, 0, 0)));
      @(posedge clk); #1;
    end
    dif.out_ready = 1'b1;
    wait_drain("t4");

    // 5: push and pop on the same edge while full; no drop, order kept.
    dif.out_ready = 1'b0;
    d0 = drop_cnt;
    sb.push_back(mk(6'b000000, 1, 0, 0)); send(DIT); send(GAP);
    sb.push_back(mk(6'b000001, 1, 0, 0)); send(DAH); send(GAP);
    sb.push_back(mk(6'b000000, 2, 0, 0)); send(DIT); send(DIT); send(GAP);
    sb.push_back(mk(6'b000011, 2, 0, 0)); send(DAH); send(DAH); send(GAP);
    sb.push_back(mk(6'b000010, 2, 0, 0)); send(DIT); send(DAH);
    sym = GAP; sym_valid = 1'b1; dif.out_ready = 1'b1;
    @(posedge clk); #1;
    sym_valid = 1'b0; sym = WAIT; dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_no_drop", 32'(drop_cnt - d0), 0);
    check("t5_new_head", 32'(head()), 32'(mk(6'b000001, 1, 0, 0)));
    dif.out_ready = 1'b1;
    wait_drain("t5");

    // Reset mid-character with records queued: everything is discarded.
    dif.out_ready = 1'b0;
    send(DIT); send(GAP); send(SPACE); send(DAH);
    check("rst_mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(dif.out_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_len", 32'(dif.out_len), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    dif.out_ready = 1'b1;
    sb.push_back(mk(6'b000000, 0, 1, 0));
    send(SPACE);
    sb.push_back(mk(6'b000001, 1, 0, 0));
    send(DAH); send(GAP);
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/morse_symbol_sequencer.md
Name: morse_symbol_sequencer

Overview:
Sits directly downstream of the dit/dah classifier and sequences its symbol stream into complete Morse characters. It accumulates DIT/DAH elements into a pattern register and closes a character on GAP or SPACE. Each finished character is queued as a record in a small FIFO. The FIFO feeds the character decoder/UART stage over a valid/ready handshake.

Parameters:
MAXLEN, 6, maximum elements per character; pattern width.
DEPTH, 4, output record FIFO depth; must be a power of 2 and ≥ 2.
TIMEOUT, 2**24, idle cycles before a partial character is auto-flushed; used only with MORSE_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
sym  input  3  symbol code: 0 = WAIT, 1 = DIT, 2 = DAH, 3 = GAP, 4 = SPACE; 5–7 are illegal.
sym_valid  input  1  single-cycle strobe qualifying sym.
out_pattern  output  MAXLEN  element bits; bit i = element i in arrival order; 1 = DAH, 0 = DIT; bits ≥ out_len are 0.
out_len  output  $clog2(MAXLEN+1)  element count, 0..MAXLEN.
out_word_end  output  1  a word boundary follows this character.
out_err  output  1  the character exceeded MAXLEN elements; the pattern is truncated.
out_valid  output  1  FIFO head is valid.
out_ready  input  1  consumer accepts the head.
drop  output  1  one-cycle pulse when a record is lost because the FIFO is full.
busy  output  1  1 while the state is COLLECT.

Behaviour:
- Reset: rst_n low asynchronously clears FIFO, pointers, count, pattern, len, err, prev_space and timeout counter. Outputs are out_valid = 0, out_pattern = 0, out_len = 0, out_word_end = 0, out_err = 0, drop = 0, busy = 0, state = IDLE.
- Reset mid-operation: any partial character and all queued records are discarded. No flush occurs.
- Input filtering: sym_valid with WAIT or an illegal code is ignored and changes no state. This includes prev_space.
- State IDLE (no pending elements):
  - DIT/DAH: store the element at bit 0, len = 1, go to COLLECT.
  - GAP: ignored.
  - SPACE: push {pattern 0, len 0, word_end 1, err 0} unless prev_space = 1, in which case it is ignored (repeated spaces collapse).
- State COLLECT:
  - DIT/DAH with len < MAXLEN: write bit[len], then len += 1.
  - DIT/DAH with len = MAXLEN: set err; pattern and len stay unchanged.
  - GAP: push {pattern, len, 0, err}, clear the accumulator, go to IDLE.
  - SPACE: push {pattern, len, 1, err}, clear the accumulator, go to IDLE.
- prev_space: set by any accepted SPACE; cleared by any accepted DIT, DAH or GAP.
- Latency: a push on cycle n makes the record visible at the FIFO head on cycle n+1 when the FIFO was empty.
- FIFO outputs: out_* reflect the head entry. The head is held stable while out_valid && !out_ready. A pop occurs when out_valid && out_ready.
- FIFO full:
  - A push with count = DEPTH and no same-cycle pop drops the record and pulses drop for 1 cycle.
  - The accumulator still clears and the state still returns to IDLE.
  - Push and pop in the same cycle while full are both accepted; count is unchanged.
- Empty: out_valid = 0; out_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Optional Feature:
MORSE_TIMEOUT_EN:
- Defined:
  - A counter runs while the state is COLLECT and resets on every accepted symbol.
  - When it reaches TIMEOUT-1 with no symbol that cycle, a record {pattern, len, 1, err} is pushed and the state returns to IDLE. This covers a trailing character with no closing GAP.
  - prev_space is set after the timeout push.
  - A symbol arriving on the timeout cycle takes priority and the timeout is cancelled.
- Not defined: no counter exists; a partial character waits indefinitely for GAP or SPACE.

Test Plan:
1. DIT, DAH, GAP with out_ready = 1 → one record {pattern 6'b000010, len 2, word_end 0, err 0}; out_valid is high exactly 1 cycle after the GAP strobe.
2. DAH, DIT, DIT, SPACE, SPACE, SPACE → record {6'b000001, 3, 1, 0} only; the repeated spaces add no records. A following SPACE after a DIT/GAP character yields one {0, 0, 1, 0} record.
3. Seven DITs then GAP (MAXLEN = 6) → {6'b000000, 6, 0, 1}. Then eight DAHs then GAP → {6'b111111, 6, 0, 1}, with err clear on the following character.
4. out_ready = 0; send 5 single-DIT characters (DEPTH = 4) → 4 records held, drop pulses once on the 5th GAP. Raising out_ready drains exactly 4 records in order, with the head stable during the stall.
5. FIFO full with out_ready = 1 on the same cycle as a GAP push → no drop; count stays 4; order preserved. Assert rst_n low mid-character → out_valid = 0, busy = 0 immediately; the next character is clean.
6. With MORSE_TIMEOUT_EN and TIMEOUT = 16: DAH then silence → at cycle 16 after the DAH, record {6'b000001, 1, 1, 0} is pushed. A DIT arriving on cycle 15 instead extends the character.
